// File: rtl/uart_rx_if.sv
// ============================================================================
//  Module      : uart_rx_if
//  Description : Signal bundle between the serial line / configuration side
//                and the uart_rx receiver.
//                  RX_IN      - serial line, idle high, asynchronous
//                  PAR_EN     - 1 = frame carries a parity bit
//                  PAR_TYP    - 0 = even parity, 1 = odd parity
//                  P_DATA     - last correctly received data word
//                  DATA_VALID - one-cycle pulse when P_DATA is updated
//                  PAR_ERR    - one-cycle pulse on parity mismatch
//                  STP_ERR    - one-cycle pulse when stop bit sampled 0
//                  Busy       - high while a frame is being received
//                Modports: master = line/consumer side, slave = receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if #(
    parameter int P_data_width = 8
);
    logic                    RX_IN;
    logic                    PAR_EN;
    logic                    PAR_TYP;
    logic [P_data_width-1:0] P_DATA;
    logic                    DATA_VALID;
    logic                    PAR_ERR;
    logic                    STP_ERR;
    logic                    Busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Start bit, P_data_width data bits LSB first,
//                optional parity bit, one stop bit. Bits are sampled at the
//                mid-bit point; the frame completes at mid stop bit.
//  Ports       : CLK   - master clock, rising edge
//                RST   - asynchronous active-high reset
//                rx_if - uart_rx_if.slave (RX_IN, PAR_EN, PAR_TYP in;
//                        P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy out)
//  Option      : UART_RX_MAJORITY_VOTE_EN - each bit is the 2-of-3 majority
//                of samples at MID-1, MID, MID+1 (decided at MID+1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLK_freq     = 200_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int P_data_width = 8
) (
    input  wire logic  CLK,
    input  wire logic  RST,
    uart_rx_if.slave   rx_if
);

    localparam int CLK_Ticks = CLK_freq / BAUD_RATE;
    localparam int MID       = CLK_Ticks / 2;
    localparam int TW        = (CLK_Ticks > 1) ? $clog2(CLK_Ticks) : 1;
    localparam int BW        = (P_data_width > 1) ? $clog2(P_data_width) : 1;

    localparam logic [TW-1:0] C_LAST_TICK = TW'(CLK_Ticks - 1);
    localparam logic [BW-1:0] C_LAST_BIT  = BW'(P_data_width - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [TW-1:0] C_PRE_TICK  = TW'(MID - 1);
    localparam logic [TW-1:0] C_MID_TICK  = TW'(MID);
    localparam logic [TW-1:0] C_DEC_TICK  = TW'(MID + 1);
`else
    localparam logic [TW-1:0] C_DEC_TICK  = TW'(MID);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    rx_meta_q;
    logic                    rx_s_q;
    logic                    rx_prev_q;
    logic [TW-1:0]           tick_q;
    logic [TW-1:0]           tick_d;
    logic [BW-1:0]           bit_cnt_q;
    logic [P_data_width-1:0] shift_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_bad_q;
    logic [P_data_width-1:0] p_data_q;
    logic                    data_valid_q;
    logic                    par_err_q;
    logic                    stp_err_q;
    logic                    busy_q;

    logic                    w_start_edge;
    logic                    w_take;
    logic                    w_bit;

    // Two-flop synchronizer plus a delayed copy for 1->0 edge detection.
    // All three reset high so a line that idles high never looks like a start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_if.RX_IN;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        tick_d       = (tick_q == C_LAST_TICK) ? '0 : tick_q + 1'b1;
        w_start_edge = rx_prev_q & ~rx_s_q;
        w_take       = (tick_q == C_DEC_TICK);
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote0_q;
    logic vote1_q;

    // Capture the two earlier votes; the third is the live synchronized value
    // at the decision tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            if (tick_q == C_PRE_TICK) vote0_q <= rx_s_q;
            if (tick_q == C_MID_TICK) vote1_q <= rx_s_q;
        end
    end

    always_comb begin
        w_bit = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
    end
`else
    always_comb begin
        w_bit = rx_s_q;
    end
`endif

    // Receive FSM with registered outputs. Status strobes default low every
    // cycle so each one is a single-cycle pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_start_edge) begin
                        state_q   <= S_START;
                        tick_q    <= '0;
                        bit_cnt_q <= '0;
                        par_bad_q <= 1'b0;
                        // Frame configuration is frozen for the whole frame.
                        par_en_q  <= rx_if.PAR_EN;
                        par_typ_q <= rx_if.PAR_TYP;
                        busy_q    <= 1'b1;
                    end
                end
                S_START: begin
                    tick_q <= tick_d;
                    if (w_take) begin
                        if (w_bit) begin
                            // Line back high at mid start bit: a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    tick_q <= tick_d;
                    if (w_take) begin
                        shift_q <= {w_bit, shift_q[P_data_width-1:1]};
                        if (bit_cnt_q == C_LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    tick_q <= tick_d;
                    if (w_take) begin
                        par_bad_q <= (w_bit != ((^shift_q) ^ par_typ_q));
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    tick_q <= tick_d;
                    if (w_take) begin
                        // Finish at mid stop bit to absorb baud mismatch.
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        par_err_q <= par_bad_q;
                        stp_err_q <= ~w_bit;
                        if (w_bit && !par_bad_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.DATA_VALID = data_valid_q;
    assign rx_if.PAR_ERR    = par_err_q;
    assign rx_if.STP_ERR    = stp_err_q;
    assign rx_if.Busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are driven bit by
//                bit; each expected DATA_VALID / error event is queued with
//                its expected cycle and checked by a monitor on the falling
//                clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int T        = CLK_FREQ / BAUD;   // 16 clocks per bit
    localparam int MIDT     = T / 2;             // 8
    localparam int W        = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT_BASE = 4;
`else
    localparam int LAT_BASE = 3;
`endif

    typedef struct {
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    logic [7:0] last_good;

    uart_rx_if #(.P_data_width(W)) bus ();

    uart_rx #(
        .CLK_freq    (CLK_FREQ),
        .BAUD_RATE   (BAUD),
        .P_data_width(W)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .rx_if(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    // Monitor: every status event must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (sb.size() == 0) begin
                n_tests = n_tests + 1;
                n_fail  = n_fail + 1;
                $display("FAIL unexpected_event cyc=%0d dv=%0b pe=%0b se=%0b data=%02h",
                         cyc, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_tests = n_tests + 1;
                if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== {e.dv, e.pe, e.se}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL event_flags got dv/pe/se=%0b%0b%0b expected %0b%0b%0b",
                             bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, e.dv, e.pe, e.se);
                end
                n_tests = n_tests + 1;
                if (bus.P_DATA !== e.data) begin
                    n_fail = n_fail + 1;
                    $display("FAIL event_pdata got %02h expected %02h", bus.P_DATA, e.data);
                end
                n_tests = n_tests + 1;
                if (cyc !== e.cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL event_latency got cycle %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        bus.RX_IN = b;
        repeat (T) @(posedge CLK);
        #1;
    endtask

    task automatic idle_bits(input int n);
        bus.RX_IN = 1'b1;
        repeat (n * T) @(posedge CLK);
        #1;
    endtask

    // Drives one frame starting #1 after a rising edge; queues the expectation.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input bit par_bit,
                              input bit stop_bit, input bit exp_dv, input bit exp_pe,
                              input bit exp_se);
        exp_t e;
        int   cap;
        cap    = cyc + 1;
        e.dv   = exp_dv;
        e.pe   = exp_pe;
        e.se   = exp_se;
        if (exp_dv) last_good = d;
        e.data = last_good;
        e.cyc  = cap + LAT_BASE + MIDT + (W + 1 + (with_par ? 1 : 0)) * T;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        bus.RX_IN = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * T; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
        end
        if (!ok) sb.delete();
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_tests = n_tests + 1;
        if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.Busy} !== 4'b0000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_flags got %04b expected 0000",
                     {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.Busy});
        end
        n_tests = n_tests + 1;
        if (bus.P_DATA !== 8'h00) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_pdata got %02h expected 00", bus.P_DATA);
        end
        RST = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_parity_even;
        bit ok;
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b0;
        @(posedge CLK); #1;
        send_frame(8'h87, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain(ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL even_timeout got drained=%0b expected 1", ok);
        end
        idle_bits(1);
    endtask

    task automatic test_parity_odd;
        bit ok;
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b1;
        @(posedge CLK); #1;
        fork
            send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            begin
                // Configuration changes mid-frame must not affect this frame.
                repeat (3 * T) @(posedge CLK);
                bus.PAR_TYP = 1'b0;
                bus.PAR_EN  = 1'b0;
            end
        join
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b1;
        wait_drain(ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL odd_timeout got drained=%0b expected 1", ok);
        end
        idle_bits(1);
    endtask

    task automatic test_parity_error;
        bit ok;
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b1;
        @(posedge CLK); #1;
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain(ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL parerr_timeout got drained=%0b expected 1", ok);
        end
        n_tests = n_tests + 1;
        if (bus.P_DATA !== 8'h55) begin
            n_fail = n_fail + 1;
            $display("FAIL parerr_pdata_hold got %02h expected 55", bus.P_DATA);
        end
        idle_bits(1);
    endtask

    task automatic test_stop_error;
        bit ok;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        @(posedge CLK); #1;
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Line must return high before a new start edge can be seen.
        drive_bit(1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain(ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL stperr_timeout got drained=%0b expected 1", ok);
        end
        idle_bits(1);
    endtask

    task automatic test_back_to_back;
        bit ok;
        bus.PAR_EN  = 1'b0;
        @(posedge CLK); #1;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain(ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_timeout got drained=%0b expected 1", ok);
        end
        idle_bits(1);
    endtask

    task automatic test_glitch;
        bit busy_seen;
        busy_seen = 1'b0;
        @(posedge CLK); #1;
        bus.RX_IN = 1'b0;
        repeat (MIDT / 2) @(posedge CLK);
        #1;
        bus.RX_IN = 1'b1;
        for (int i = 0; i < 2 * T; i++) begin
            @(negedge CLK);
            if (bus.Busy) busy_seen = 1'b1;
        end
        n_tests = n_tests + 1;
        if (busy_seen !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_busy_pulse got %0b expected 1", busy_seen);
        end
        n_tests = n_tests + 1;
        if (bus.Busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_busy_end got %0b expected 0", bus.Busy);
        end
        n_tests = n_tests + 1;
        if (bus.P_DATA !== last_good) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_pdata got %02h expected %02h", bus.P_DATA, last_good);
        end
        idle_bits(1);
    endtask

    task automatic test_reset_midframe;
        bit ok;
        logic [7:0] d;
        d = 8'h87;
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b0;
        @(posedge CLK); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        bus.RX_IN = d[4];
        repeat (MIDT) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        n_tests = n_tests + 1;
        if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.Busy} !== 4'b0000) begin
            n_fail = n_fail + 1;
            $display("FAIL async_reset_flags got %04b expected 0000",
                     {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.Busy});
        end
        n_tests = n_tests + 1;
        if (bus.P_DATA !== 8'h00) begin
            n_fail = n_fail + 1;
            $display("FAIL async_reset_pdata got %02h expected 00", bus.P_DATA);
        end
        last_good = 8'h00;
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        idle_bits(2);
        send_frame(8'h87, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain(ok);
        n_tests = n_tests + 1;
        if (ok !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_timeout got drained=%0b expected 1", ok);
        end
        idle_bits(1);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        last_good   = 8'h00;
        RST         = 1'b1;
        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;

        test_reset();
        test_parity_even();
        test_parity_odd();
        test_parity_error();
        test_stop_error();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();

        n_tests = n_tests + 1;
        if (sb.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
